// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers and MTHI/MTLO moves.
// Optional multiply-accumulate (ops 6/7 as MADD/MADDU) is enabled by defining MDU_MADD_EN.
module mul_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             fsm_state
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_N  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N   = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;
`endif

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
`ifdef MDU_MADD_EN
    logic [2*WIDTH-1:0] acc_q;
`endif

    logic               is_arith;
    logic [CNT_W-1:0]   load_n;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic signed [WIDTH-1:0] quot_s;
    logic signed [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0]   quot_u;
    logic [WIDTH-1:0]   rem_u;
    logic [2*WIDTH-1:0] result;

    assign fsm_state = (state == RUN);

    always_comb begin
        is_arith = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        load_n   = ((op == OP_DIV) || (op == OP_DIVU)) ? DIV_N : MULT_N;
`ifdef MDU_MADD_EN
        if ((op == OP_MADD) || (op == OP_MADDU)) begin
            is_arith = 1'b1;
        end
`endif
    end

    // Operands are explicitly widened so the product keeps all 2*WIDTH bits.
    always_comb begin
        prod_s = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) * $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
        prod_u = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
        quot_s = $signed(op_a) / $signed(op_b);
        rem_s  = $signed(op_a) % $signed(op_b);
        quot_u = op_a / op_b;
        rem_u  = op_a % op_b;
    end

    // Divide-by-zero and signed overflow are overridden so results never depend on / or % corner behaviour.
    always_comb begin
        result = {hi, lo};
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV: begin
                if (op_b == '0) begin
                    result = {op_a, ALL_ONES};
                end else if ((op_a == MIN_NEG) && (op_b == ALL_ONES)) begin
                    result = {{WIDTH{1'b0}}, op_a};
                end else begin
                    result = {rem_s, quot_s};
                end
            end
            OP_DIVU: begin
                if (op_b == '0) begin
                    result = {op_a, ALL_ONES};
                end else begin
                    result = {rem_u, quot_u};
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  result = acc_q + prod_s;
            OP_MADDU: result = acc_q + prod_u;
`endif
            default:  result = {hi, lo};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            op_q  <= '0;
            op_a  <= '0;
            op_b  <= '0;
`ifdef MDU_MADD_EN
            acc_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_arith) begin
                            op_q  <= op;
                            op_a  <= a;
                            op_b  <= b;
                            count <= load_n;
                            busy  <= 1'b1;
                            state <= RUN;
`ifdef MDU_MADD_EN
                            acc_q <= {hi, lo};
`endif
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    // Starts are ignored here; the result lands on the same edge busy drops.
                    if (count == CNT_ONE) begin
                        {hi, lo} <= result;
                        busy     <= 1'b0;
                        count    <= '0;
                        state    <= IDLE;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: timing, arithmetic corners, moves, ignore rules and reset abort.
// Define MDU_MADD_EN for both bench and RTL to exercise the accumulate ops.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        fsm_state;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents one request for a single edge; returns 1ns after that edge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = '0;
        b     = '0;
    endtask

    // Counts edges until busy is low, bounded so a stuck unit cannot hang the run.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %0h exp 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %0h exp 0", lo); end
        checks++; if (fsm_state !== 1'b0) begin errors++; $display("FAIL reset_state got %0h exp 0", fsm_state); end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mt();
        run_op(3'd4, 32'h1234, 32'h0);
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi got %0h exp 1234", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %0h exp 0", busy); end
        run_op(3'd5, 32'h5678, 32'h0);
        checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo_lo got %0h exp 5678", lo); end
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mtlo_hi_kept got %0h exp 1234", hi); end
    endtask

    task automatic test_mult();
        int cyc;
        run_op(3'd0, 32'hFFFFFFFE, 32'd3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy_rise got %0h exp 1", busy); end
        @(posedge clk);
        #1;
        checks++; if (hi !== 32'h1234 || lo !== 32'h5678) begin
            errors++; $display("FAIL mult_hold got %0h_%0h exp 1234_5678", hi, lo);
        end
        wait_idle(cyc);
        checks++; if (cyc + 1 !== 5) begin errors++; $display("FAIL mult_latency got %0d exp 5", cyc + 1); end
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            errors++; $display("FAIL mult_result got %0h_%0h exp ffffffff_fffffffa", hi, lo);
        end
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(cyc);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL multu_latency got %0d exp 5", cyc); end
        checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            errors++; $display("FAIL multu_result got %0h_%0h exp fffffffe_1", hi, lo);
        end
    endtask

    task automatic test_div();
        logic [2:0]  v_op [6] = '{3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd3};
        logic [31:0] v_a  [6] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd7, 32'hFFFFFFFB, 32'd100};
        logic [31:0] v_b  [6] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'd7};
        logic [31:0] v_hi [6] = '{32'hFFFFFFFF, 32'd7, 32'h0, 32'd1, 32'hFFFFFFFB, 32'd2};
        logic [31:0] v_lo [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14};
        int cyc;
        for (int i = 0; i < 6; i++) begin
            run_op(v_op[i], v_a[i], v_b[i]);
            wait_idle(cyc);
            checks++; if (cyc !== 10) begin errors++; $display("FAIL div_latency[%0d] got %0d exp 10", i, cyc); end
            checks++; if (hi !== v_hi[i] || lo !== v_lo[i]) begin
                errors++; $display("FAIL div_result[%0d] got %0h_%0h exp %0h_%0h", i, hi, lo, v_hi[i], v_lo[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        run_op(3'd0, 32'd3, 32'd4);
        start = 1'b1; op = 3'd5; a = 32'hDEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL ignore_mtlo_lo got %0h exp e", lo); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %0h exp 1", busy); end
        start = 1'b1; op = 3'd0; a = 32'd100; b = 32'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL ignore_remaining got %0d exp 3", cyc); end
        checks++; if (hi !== 32'h0 || lo !== 32'd12) begin
            errors++; $display("FAIL ignore_result got %0h_%0h exp 0_c", hi, lo);
        end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd();
        int cyc;
        run_op(3'd4, 32'h0, 32'h0);
        run_op(3'd5, 32'hFFFFFFFF, 32'h0);
        run_op(3'd7, 32'd1, 32'd1);
        wait_idle(cyc);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL maddu_latency got %0d exp 5", cyc); end
        checks++; if (hi !== 32'd1 || lo !== 32'd0) begin
            errors++; $display("FAIL maddu_result got %0h_%0h exp 1_0", hi, lo);
        end
        run_op(3'd6, 32'hFFFFFFFF, 32'd1);
        wait_idle(cyc);
        checks++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL madd_result got %0h_%0h exp 0_ffffffff", hi, lo);
        end
    endtask
`else
    task automatic test_reserved();
        run_op(3'd4, 32'hAAAA, 32'h0);
        run_op(3'd5, 32'hBBBB, 32'h0);
        run_op(3'd6, 32'd5, 32'd5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reserved6_busy got %0h exp 0", busy); end
        run_op(3'd7, 32'd5, 32'd5);
        repeat (6) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reserved7_busy got %0h exp 0", busy); end
        checks++; if (hi !== 32'hAAAA || lo !== 32'hBBBB) begin
            errors++; $display("FAIL reserved_hold got %0h_%0h exp aaaa_bbbb", hi, lo);
        end
    endtask
`endif

    task automatic test_back_to_back();
        int cyc;
        run_op(3'd0, 32'd2, 32'd3);
        wait_idle(cyc);
        checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd6) begin
            errors++; $display("FAIL b2b_first got busy=%0h %0h_%0h exp busy=0 0_6", busy, hi, lo);
        end
        run_op(3'd3, 32'd100, 32'd7);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %0h exp 1", busy); end
        wait_idle(cyc);
        checks++; if (cyc !== 10 || hi !== 32'd2 || lo !== 32'd14) begin
            errors++; $display("FAIL b2b_second got cyc=%0d %0h_%0h exp cyc=10 2_e", cyc, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        run_op(3'd0, 32'h10, 32'h10);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0h exp 0", busy); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL rstmid_clear got %0h_%0h exp 0_0", hi, lo);
        end
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL rstmid_nowrite got busy=%0h %0h_%0h exp busy=0 0_0", busy, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mt();
        test_mult();
        test_div();
        test_busy_ignore();
`ifdef MDU_MADD_EN
        test_madd();
`else
        test_reserved();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
